// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard unit:
//                FSM state encoding, EX operand forward-select encoding,
//                stall-length constants and the forward-select priority
//                function.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Stall-control FSM states
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Stall lengths in cycles
    localparam logic [1:0] C_STALL_LEN_0 = 2'd0;
    localparam logic [1:0] C_STALL_LEN_1 = 2'd1;
    localparam logic [1:0] C_STALL_LEN_2 = 2'd2;

    // Operand select for the next EX stage. The producer now in ID_EX will sit
    // in EX_MEM next cycle, so it is the youngest value and wins over the
    // producer now in EX_MEM (which moves on to MEM_WB).
    function automatic fwd_sel_t fwd_select(
        input logic match_ex,
        input logic wr_ex,
        input logic match_mem,
        input logic wr_mem
    );
        if (match_ex && wr_ex) begin
            return FWD_MEM;
        end else if (match_mem && wr_mem) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational hazard classification. Flags load-use,
//                branch-on-ALU/load-result and branch-after-load hazards and
//                reports the stall length required.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect (
    input  logic       zero1,
    input  logic       zero2,
    input  logic       zero3,
    input  logic       zero4,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_RegWrite,
    input  logic       EX_MEM_MemRead,
    input  logic       IF_ID_Branch,
    output logic       stall_req,
    output logic [1:0] stall_len
);
    import hazard_pkg::*;

    logic w_load_use;
    logic w_br_on_ex;
    logic w_br_after_load;

    // A branch compares in ID, so it waits for an ALU result one cycle and a
    // load result two cycles; plain instructions only wait on a load.
    assign w_load_use      = (zero1 | zero2) & ID_EX_MemRead & ID_EX_RegWrite & ~IF_ID_Branch;
    assign w_br_on_ex      = IF_ID_Branch & (zero1 | zero2) & ID_EX_RegWrite;
    assign w_br_after_load = IF_ID_Branch & (zero3 | zero4) & EX_MEM_MemRead;

    // Longest applicable stall wins
    always_comb begin
        stall_req = w_load_use | w_br_on_ex | w_br_after_load;
        stall_len = C_STALL_LEN_0;
        if (w_br_on_ex && ID_EX_MemRead) begin
            stall_len = C_STALL_LEN_2;
        end else if (stall_req) begin
            stall_len = C_STALL_LEN_1;
        end
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard control. Stalls PC/IF_ID and inserts ID_EX
//                bubbles for data hazards, flushes IF_ID on taken branches,
//                and generates registered EX forwarding selects plus
//                combinational ID branch-comparator forwarding.
//  Options     : HAZARD_PERF_CNT_EN - adds saturating 32-bit stall_cycles and
//                flush_count outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        zero1,
    input  logic        zero2,
    input  logic        zero3,
    input  logic        zero4,
    input  logic        zeroa,
    input  logic        zerob,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_RegWrite,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_RegWrite,
    input  logic        MEM_WB_RegWrite,
    input  logic        IF_ID_Branch,
    input  logic        branch_taken,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        ID_EX_bubble,
    output logic        IF_ID_flush,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        BrFwdA,
    output logic        BrFwdB
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    import hazard_pkg::*;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    fwd_sel_t   r_fwd_a;
    fwd_sel_t   r_fwd_b;
    logic       w_stall_req;
    logic [1:0] w_stall_len;
    logic       w_stall;
    logic       w_flush;
    logic       w_unused_wb;

    // The register file is write-first, so MEM_WB matches never need a bypass
    assign w_unused_wb = zeroa | zerob | MEM_WB_RegWrite;

    hazard_detect u_detect (
        .zero1          (zero1),
        .zero2          (zero2),
        .zero3          (zero3),
        .zero4          (zero4),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .EX_MEM_MemRead (EX_MEM_MemRead),
        .IF_ID_Branch   (IF_ID_Branch),
        .stall_req      (w_stall_req),
        .stall_len      (w_stall_len)
    );

    // FSM state and remaining-stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and stall decision. The request cycle itself is the first
    // stalled cycle, so a 1-cycle stall completes in RUN and only longer
    // stalls enter STALL carrying the extra cycles in cnt. Requests seen in
    // STALL are ignored; the last STALL cycle is the one where cnt drops to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_stall_req) begin
                    w_stall = 1'b1;
                    if (w_stall_len > C_STALL_LEN_1) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = w_stall_len - 2'd1;
                    end
                end else begin
                    w_flush = IF_ID_Branch & branch_taken;
                end
            end
            ST_STALL: begin
                w_stall   = 1'b1;
                w_cnt_nxt = (r_cnt != 2'd0) ? r_cnt - 2'd1 : 2'd0;
                if (w_cnt_nxt == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign PC_write     = ~w_stall;
    assign IF_ID_write  = ~w_stall;
    assign ID_EX_bubble = w_stall;
    assign IF_ID_flush  = w_flush;

    // Registered EX forwarding selects; a bubble carries no operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_stall) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_fwd_a <= fwd_select(zero1, ID_EX_RegWrite, zero3, EX_MEM_RegWrite);
            r_fwd_b <= fwd_select(zero2, ID_EX_RegWrite, zero4, EX_MEM_RegWrite);
        end
    end

    assign ForwardA = r_fwd_a;
    assign ForwardB = r_fwd_b;

    // Branch comparator bypass from EX_MEM; load data there is not ready yet
    assign BrFwdA = IF_ID_Branch & zero3 & EX_MEM_RegWrite & ~EX_MEM_MemRead;
    assign BrFwdB = IF_ID_Branch & zero4 & EX_MEM_RegWrite & ~EX_MEM_MemRead;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
- REQ-001 SHALL have one clock and asynchronous active-high reset: clk, rst.
- REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
- REQ-003 rst  in  1  asynchronous, active-high reset.
- REQ-004 zero1, zero2  in  1 each  IF_ID rs1/rs2 matches nonzero ID_EX rd.
- REQ-005 zero3, zero4  in  1 each  IF_ID rs1/rs2 matches nonzero EX_MEM rd.
- REQ-006 zeroa, zerob  in  1 each  IF_ID rs1/rs2 matches nonzero MEM_WB rd.
- REQ-007 ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, EX_MEM_RegWrite, MEM_WB_RegWrite  in  1 each  pipeline control bits.
- REQ-008 IF_ID_Branch  in  1  ID-stage instruction is a conditional branch resolved in ID.
- REQ-009 branch_taken  in  1  ID branch comparator result, valid only when IF_ID_Branch=1.
- REQ-010 PC_write, IF_ID_write  out  1 each  0 = hold PC / IF_ID register.
- REQ-011 ID_EX_bubble  out  1  1 = load NOP controls into ID_EX.
- REQ-012 IF_ID_flush  out  1  1 = squash the IF_ID instruction (taken branch).
- REQ-013 ForwardA, ForwardB  out  2 each  registered EX operand select: 00 regfile, 10 EX_MEM, 01 MEM_WB.
- REQ-014 BrFwdA, BrFwdB  out  1 each  combinational: feed the EX_MEM ALU result to the ID branch comparator.

Function
- REQ-015 Load-use hazard: (zero1|zero2)&ID_EX_MemRead with ID_EX_RegWrite, non-branch, SHALL request a stall of 1.
- REQ-016 Branch hazard: IF_ID_Branch&(zero1|zero2)&ID_EX_RegWrite SHALL request a stall of 2 if ID_EX_MemRead, else 1.
- REQ-017 Branch-after-load hazard: IF_ID_Branch&(zero3|zero4)&EX_MEM_MemRead SHALL request a stall of 1.
- REQ-018 FSM states RUN and STALL, with a 2-bit counter cnt; in RUN a request SHALL go to STALL with cnt=request-1.
- REQ-019 In STALL, new requests SHALL be ignored; cnt SHALL decrement each cycle; the FSM SHALL leave for RUN when cnt=0.
- REQ-020 During any cycle with a request (RUN) or in STALL: PC_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
- REQ-021 A 2-cycle stall SHALL hold outputs stalled for exactly 2 consecutive cycles; a 1-cycle stall for exactly 1.
- REQ-022 IF_ID_flush SHALL be 1 only in RUN, with no request, when IF_ID_Branch&branch_taken.
- REQ-023 Next ForwardA: zero1&ID_EX_RegWrite -> 10; else zero3&EX_MEM_RegWrite -> 01; else 00. This priority SHALL also hold on simultaneous matches.
- REQ-024 ForwardB SHALL follow the REQ-023 rules using zero2/zero4.
- REQ-025 ForwardA/B SHALL be registered each cycle; on a bubble cycle they SHALL load 00.
- REQ-026 zeroa/zerob SHALL NOT produce forwarding, because the register file is write-first.
- REQ-027 BrFwdA SHALL equal IF_ID_Branch&zero3&EX_MEM_RegWrite&!EX_MEM_MemRead; BrFwdB SHALL be the same with zero4.

Reset
- REQ-028 rst SHALL asynchronously force state=RUN, cnt=0, ForwardA=ForwardB=00.
- REQ-029 rst asserted mid-stall SHALL abort the stall; PC_write=1 from the first edge after deassertion, absent requests.

Configuration
- REQ-030 With HAZARD_PERF_CNT_EN defined, 32-bit outputs stall_cycles and flush_count SHALL count stalled cycles and flush pulses.
- REQ-031 Both counters SHALL saturate at 0xFFFFFFFF and reset to 0.
- REQ-032 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent.

Structure
- REQ-033 Package hazard_pkg SHALL hold the FSM state enum, the fwd_sel_t enum (FWD_RF=00, FWD_MEM=10, FWD_WB=01) and the stall-length constants.
- REQ-034 Sub-module hazard_detect SHALL hold the combinational classification (REQ-015..017), outputting stall_req and stall_len[1:0].

Verification
- REQ-035 Load in ID_EX, zero1=1, ID_EX_MemRead=1 -> one cycle with PC_write=0, ID_EX_bubble=1, then ForwardA=01.
- REQ-036 Branch, zero2=1, ID_EX_MemRead=1 -> exactly 2 stall cycles; a zero4 request in cycle 2 is ignored; then BrFwdB=0 (load data via MEM_WB).
- REQ-037 zero1=zero3=1, both RegWrite=1, no load -> next ForwardA=10 (EX_MEM wins).
- REQ-038 Branch, branch_taken=1, no matches -> IF_ID_flush=1 for 1 cycle, PC_write=1.
- REQ-039 rst pulsed in cycle 1 of a 2-cycle stall -> state RUN, ForwardA/B=00, PC_write=1 next cycle.
- REQ-040 HAZARD_PERF_CNT_EN defined: 3 stall cycles plus 1 flush -> stall_cycles=3, flush_count=1.
